// File: rtl/adc_align_ctrl.sv
// Sequences ADC lanes through frame alignment: waits for lock, bitslips each lane until FRAME_PATTERN matches.
// Optional ADC_ALIGN_MONITOR_EN: round-robin recheck in DONE, realigns a lane after 3 consecutive misses.
`timescale 1ns/1ps
module adc_align_ctrl #(
  parameter int             S             = 8,
  parameter int             D             = 16,
  parameter logic [D-1:0]   FRAME_PATTERN = 16'hFF00,
  parameter int             MAX_SLIP      = 8,
  parameter int             SETTLE_CYC    = 16,
  localparam int            LW            = (S > 1) ? $clog2(S) : 1
) (
  input  logic                  ref_clk,
  input  logic                  ref_rst_n,
  input  logic                  start,
  input  logic                  delay_ready,
  input  logic [S-1:0]          rx_locked,
  input  logic [S-1:0][D-1:0]   frame_word,
  output logic [S-1:0]          bitslip,
  output logic [S-1:0]          lane_aligned,
  output logic                  busy,
  output logic                  align_done,
  output logic                  align_fail,
  output logic [LW-1:0]         fail_lane
);

  localparam int             SCW         = $clog2(MAX_SLIP + 1);
  localparam logic [SCW-1:0] MAX_SLIP_C  = SCW'(MAX_SLIP);
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [LW-1:0]  LAST_LANE   = LW'(S - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, CHECK, SLIP, SETTLE, NEXT, DONE, FAIL
  } state_t;

  state_t          state_q;
  logic [LW-1:0]   lane_q;
  logic [SCW-1:0]  slip_cnt_q;
  logic [7:0]      settle_cnt_q;
  logic [S-1:0]    bitslip_q;
  logic [S-1:0]    lane_aligned_q;
  logic            busy_q;
  logic            align_done_q;
  logic            align_fail_q;
  logic [LW-1:0]   fail_lane_q;
`ifdef ADC_ALIGN_MONITOR_EN
  logic [LW-1:0]       mon_lane_q;
  logic [S-1:0][1:0]   mon_miss_q;
`endif

  logic          lane_ok;
  logic          lane_match;
  logic [S-1:0]  lane_onehot;

  assign lane_ok     = delay_ready & rx_locked[lane_q];
  assign lane_match  = (frame_word[lane_q] == FRAME_PATTERN);
  assign lane_onehot = S'(1) << lane_q;

  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      state_q        <= IDLE;
      lane_q         <= '0;
      slip_cnt_q     <= '0;
      settle_cnt_q   <= '0;
      bitslip_q      <= '0;
      lane_aligned_q <= '0;
      busy_q         <= 1'b0;
      align_done_q   <= 1'b0;
      align_fail_q   <= 1'b0;
      fail_lane_q    <= '0;
`ifdef ADC_ALIGN_MONITOR_EN
      mon_lane_q     <= '0;
      mon_miss_q     <= '0;
`endif
    end else begin
      bitslip_q      <= '0;
      // An aligned lane that loses lock is no longer trusted.
      lane_aligned_q <= lane_aligned_q & rx_locked;
      if (!busy_q && start) begin
        state_q        <= WAIT_RDY;
        lane_q         <= '0;
        slip_cnt_q     <= '0;
        settle_cnt_q   <= '0;
        lane_aligned_q <= '0;
        busy_q         <= 1'b1;
        align_done_q   <= 1'b0;
        align_fail_q   <= 1'b0;
        fail_lane_q    <= '0;
`ifdef ADC_ALIGN_MONITOR_EN
        mon_lane_q     <= '0;
        mon_miss_q     <= '0;
`endif
      end else begin
        case (state_q)
          WAIT_RDY: if (lane_ok) state_q <= CHECK;
          CHECK: begin
            if (!lane_ok) begin
              state_q    <= WAIT_RDY;
              slip_cnt_q <= '0;
            end else if (lane_match) begin
              lane_aligned_q <= (lane_aligned_q & rx_locked) | lane_onehot;
              state_q        <= NEXT;
            end else if (slip_cnt_q < MAX_SLIP_C) begin
              bitslip_q <= lane_onehot;
              state_q   <= SLIP;
            end else begin
              state_q      <= FAIL;
              align_fail_q <= 1'b1;
              fail_lane_q  <= lane_q;
              busy_q       <= 1'b0;
            end
          end
          SLIP: begin
            if (!lane_ok) begin
              state_q    <= WAIT_RDY;
              slip_cnt_q <= '0;
            end else begin
              slip_cnt_q   <= slip_cnt_q + SCW'(1);
              settle_cnt_q <= '0;
              state_q      <= SETTLE;
            end
          end
          SETTLE: begin
            if (!lane_ok) begin
              state_q    <= WAIT_RDY;
              slip_cnt_q <= '0;
            end else if (settle_cnt_q == SETTLE_LAST) begin
              state_q <= CHECK;
            end else begin
              settle_cnt_q <= settle_cnt_q + 8'd1;
            end
          end
          NEXT: begin
            slip_cnt_q <= '0;
            if (lane_q == LAST_LANE) begin
              state_q      <= DONE;
              align_done_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              lane_q  <= lane_q + LW'(1);
              state_q <= WAIT_RDY;
            end
          end
          DONE: begin
`ifdef ADC_ALIGN_MONITOR_EN
            mon_lane_q <= (mon_lane_q == LAST_LANE) ? '0 : mon_lane_q + LW'(1);
            if (frame_word[mon_lane_q] != FRAME_PATTERN) begin
              if (mon_miss_q[mon_lane_q] == 2'd2) begin
                lane_aligned_q[mon_lane_q] <= 1'b0;
                align_done_q <= 1'b0;
                busy_q       <= 1'b1;
                lane_q       <= mon_lane_q;
                slip_cnt_q   <= '0;
                state_q      <= WAIT_RDY;
                mon_lane_q   <= '0;
                mon_miss_q   <= '0;
              end else begin
                mon_miss_q[mon_lane_q] <= mon_miss_q[mon_lane_q] + 2'd1;
              end
            end else begin
              mon_miss_q[mon_lane_q] <= 2'd0;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bitslip      = bitslip_q;
  assign lane_aligned = lane_aligned_q;
  assign busy         = busy_q;
  assign align_done   = align_done_q;
  assign align_fail   = align_fail_q;
  assign fail_lane    = fail_lane_q;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed bench for adc_align_ctrl with a behavioural lane model that matches after a set number of bitslips.
`timescale 1ns/1ps
module tb_adc_align_ctrl;
  localparam int S = 8;
  localparam int D = 16;
  localparam logic [D-1:0] PAT = 16'hFF00;

  logic                ref_clk = 1'b0;
  logic                ref_rst_n = 1'b0;
  logic                start = 1'b0;
  logic                delay_ready = 1'b0;
  logic [S-1:0]        rx_locked = '0;
  logic [S-1:0][D-1:0] frame_word;
  logic [S-1:0]        bitslip;
  logic [S-1:0]        lane_aligned;
  logic                busy;
  logic                align_done;
  logic                align_fail;
  logic [2:0]          fail_lane;

  adc_align_ctrl dut (
    .ref_clk      (ref_clk),
    .ref_rst_n    (ref_rst_n),
    .start        (start),
    .delay_ready  (delay_ready),
    .rx_locked    (rx_locked),
    .frame_word   (frame_word),
    .bitslip      (bitslip),
    .lane_aligned (lane_aligned),
    .busy         (busy),
    .align_done   (align_done),
    .align_fail   (align_fail),
    .fail_lane    (fail_lane)
  );

  always #5 ref_clk = ~ref_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt [S] = '{default: 0};
  int last_t    [S] = '{default: -1};
  int min_gap   [S] = '{default: 100000};
  int base      [S] = '{default: 0};
  int need      [S] = '{default: 0};
  logic [S-1:0] corrupt = '0;
  int cyc = 0;
  int multi_hot = 0;

  // Pulse bookkeeping on the falling edge, away from DUT updates.
  always @(negedge ref_clk) begin
    cyc++;
    if ($countones(bitslip) > 1) multi_hot++;
    for (int i = 0; i < S; i++) begin
      if (bitslip[i]) begin
        if (last_t[i] >= 0 && (cyc - last_t[i]) < min_gap[i]) min_gap[i] = cyc - last_t[i];
        last_t[i] = cyc;
        pulse_cnt[i]++;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < S; i++)
      frame_word[i] = (!corrupt[i] && (pulse_cnt[i] - base[i] >= need[i])) ? PAT : ~PAT;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge ref_clk) start = 1'b1;
    @(posedge ref_clk);
    #1 start = 1'b0;
  endtask

  task automatic rebase(input int nlane, input int nval);
    for (int i = 0; i < S; i++) begin
      base[i] = pulse_cnt[i];
      need[i] = 0;
    end
    if (nlane >= 0) need[nlane] = nval;
  endtask

  function automatic int pulses(input int l);
    return pulse_cnt[l] - base[l];
  endfunction

  function automatic int others(input int l);
    int s = 0;
    for (int i = 0; i < S; i++) if (i != l) s += pulse_cnt[i] - base[i];
    return s;
  endfunction

  task automatic wait_end(input string tag, input int bound);
    int c = 0;
    while (!(align_done || align_fail) && c < bound) begin
      tick(1);
      c++;
    end
    check_eq(tag, 32'(align_done | align_fail), 1);
  endtask

  task automatic wait_pulses(input string tag, input int l, input int n, input int bound);
    int c = 0;
    while (pulses(l) < n && c < bound) begin
      tick(1);
      c++;
    end
    check_eq(tag, 32'(pulses(l) >= n), 1);
  endtask

  initial begin
    int cycles;
    int snap;
    delay_ready = 1'b1;
    rx_locked   = '1;
    tick(3);
    check_eq("rst_bitslip", 32'(bitslip), 0);
    check_eq("rst_aligned", 32'(lane_aligned), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(align_done), 0);
    check_eq("rst_fail", 32'(align_fail), 0);
    check_eq("rst_fail_lane", 32'(fail_lane), 0);
    @(negedge ref_clk) ref_rst_n = 1'b1;
    tick(3);
    check_eq("idle_busy", 32'(busy), 0);

    // All lanes match immediately: 3 cycles per lane, DONE on the 24th edge.
    rebase(-1, 0);
    pulse_start();
    check_eq("a_busy_after_start", 32'(busy), 1);
    cycles = 0;
    while (!align_done && cycles < 200) begin
      tick(1);
      cycles++;
    end
    check_eq("a_latency", 32'(cycles), 24);
    check_eq("a_done", 32'(align_done), 1);
    check_eq("a_aligned", 32'(lane_aligned), 32'hFF);
    check_eq("a_busy", 32'(busy), 0);
    check_eq("a_no_slips", 32'(others(-1)), 0);

`ifdef ADC_ALIGN_MONITOR_EN
    @(negedge ref_clk) corrupt[1] = 1'b1;
    cycles = 0;
    while (align_done && cycles < 100) begin
      tick(1);
      cycles++;
    end
    corrupt[1] = 1'b0;
    check_eq("mon_done_drop", 32'(align_done), 0);
    check_eq("mon_lane1_clear", 32'(lane_aligned[1]), 0);
    check_eq("mon_busy", 32'(busy), 1);
    wait_end("mon_realign_end", 500);
    check_eq("mon_realign_done", 32'(align_done), 1);
    check_eq("mon_realign_aligned", 32'(lane_aligned), 32'hFF);
`else
    @(negedge ref_clk) corrupt[1] = 1'b1;
    tick(50);
    check_eq("nomon_done", 32'(align_done), 1);
    check_eq("nomon_aligned", 32'(lane_aligned), 32'hFF);
    @(negedge ref_clk) corrupt[1] = 1'b0;
`endif

    // Lock loss on an aligned lane clears its flag one cycle later.
    @(negedge ref_clk) rx_locked[5] = 1'b0;
    tick(1);
    check_eq("lock_drop_clear", 32'(lane_aligned), 32'hDF);
    @(negedge ref_clk) rx_locked[5] = 1'b1;
    tick(2);
    check_eq("lock_back_stays", 32'(lane_aligned), 32'hDF);

    // Lane 3 needs five slips.
    rebase(3, 5);
    pulse_start();
    wait_end("b_end", 2000);
    check_eq("b_done", 32'(align_done), 1);
    check_eq("b_pulses3", 32'(pulses(3)), 5);
    check_eq("b_other_pulses", 32'(others(3)), 0);
    check_eq("b_gap_ge18", 32'(min_gap[3] >= 18), 1);
    check_eq("b_aligned", 32'(lane_aligned), 32'hFF);
    check_eq("b_onehot", 32'(multi_hot), 0);

    // Lane 6 never matches.
    rebase(6, 1000);
    pulse_start();
    wait_end("c_end", 2000);
    check_eq("c_fail", 32'(align_fail), 1);
    check_eq("c_done", 32'(align_done), 0);
    check_eq("c_fail_lane", 32'(fail_lane), 6);
    check_eq("c_aligned", 32'(lane_aligned), 32'h3F);
    check_eq("c_pulses6", 32'(pulses(6)), 8);
    check_eq("c_busy", 32'(busy), 0);

    // Lane 2 loses lock during SETTLE after 5 slips; needs 6 more after relock.
    rebase(2, 1000);
    pulse_start();
    check_eq("d_fail_cleared", 32'(align_fail), 0);
    wait_pulses("d_five_slips", 2, 5, 2000);
    tick(3);
    @(negedge ref_clk) rx_locked[2] = 1'b0;
    tick(2);
    check_eq("d_keep_earlier", 32'(lane_aligned), 32'h03);
    check_eq("d_busy", 32'(busy), 1);
    tick(3);
    base[2] = pulse_cnt[2];
    need[2] = 6;
    @(negedge ref_clk) rx_locked[2] = 1'b1;
    wait_end("d_end", 3000);
    check_eq("d_done", 32'(align_done), 1);
    check_eq("d_pulses_after", 32'(pulses(2)), 6);
    check_eq("d_aligned", 32'(lane_aligned), 32'hFF);

    // Start while busy is ignored.
    rebase(5, 2);
    pulse_start();
    wait_pulses("e_first_slip", 5, 1, 2000);
    tick(3);
    pulse_start();
    check_eq("e_ignore_aligned", 32'(lane_aligned), 32'h1F);
    check_eq("e_ignore_busy", 32'(busy), 1);
    wait_end("e_end", 2000);
    check_eq("e_done", 32'(align_done), 1);
    check_eq("e_pulses5", 32'(pulses(5)), 2);

    // Reset asserted while bitslip is high.
    rebase(4, 1000);
    pulse_start();
    cycles = 0;
    while (!bitslip[4] && cycles < 2000) begin
      tick(1);
      cycles++;
    end
    check_eq("f_saw_slip", 32'(bitslip[4]), 1);
    #1 ref_rst_n = 1'b0;
    #1;
    check_eq("f_rst_bitslip", 32'(bitslip), 0);
    check_eq("f_rst_busy", 32'(busy), 0);
    check_eq("f_rst_aligned", 32'(lane_aligned), 0);
    check_eq("f_rst_done", 32'(align_done), 0);
    snap = pulse_cnt[4];
    tick(3);
    @(negedge ref_clk) ref_rst_n = 1'b1;
    tick(40);
    check_eq("f_no_more_slips", 32'(pulse_cnt[4] - snap), 0);
    check_eq("f_idle_busy", 32'(busy), 0);
    check_eq("f_onehot_all", 32'(multi_hot), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
